// File: rtl/rat_multiport_if.sv
`default_nettype none
// ============================================================================
//  Module      : rat_multiport_if
//  Description : Rename / commit / recover bus between the decode + free-list
//                front end (master) and the register alias table (slave).
//                Slot k of every packed vector sits at [k*W +: W].
//  Ports       : ren_valid, ren_src1_arch, ren_src2_arch, ren_dst_wen,
//                ren_dst_arch, ren_dst_phys            (master -> slave)
//                ren_src1_phys, ren_src2_phys, ren_old_phys,
//                ren_ready                             (slave -> master)
//                com_valid, com_dst_wen, com_dst_arch, com_dst_phys,
//                recover                               (master -> slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rat_multiport_if #(
    parameter int NUM_ARCH_REGS = 35,
    parameter int NUM_PHYS_REGS = 64,
    parameter int RENAME_WIDTH  = 2
);
    localparam int LA = $clog2(NUM_ARCH_REGS);
    localparam int LP = $clog2(NUM_PHYS_REGS);

    logic [RENAME_WIDTH-1:0]    ren_valid;
    logic [RENAME_WIDTH*LA-1:0] ren_src1_arch;
    logic [RENAME_WIDTH*LA-1:0] ren_src2_arch;
    logic [RENAME_WIDTH-1:0]    ren_dst_wen;
    logic [RENAME_WIDTH*LA-1:0] ren_dst_arch;
    logic [RENAME_WIDTH*LP-1:0] ren_dst_phys;
    logic [RENAME_WIDTH*LP-1:0] ren_src1_phys;
    logic [RENAME_WIDTH*LP-1:0] ren_src2_phys;
    logic [RENAME_WIDTH*LP-1:0] ren_old_phys;
    logic                       ren_ready;
    logic [RENAME_WIDTH-1:0]    com_valid;
    logic [RENAME_WIDTH-1:0]    com_dst_wen;
    logic [RENAME_WIDTH*LA-1:0] com_dst_arch;
    logic [RENAME_WIDTH*LP-1:0] com_dst_phys;
    logic                       recover;

    modport master (
        output ren_valid, ren_src1_arch, ren_src2_arch, ren_dst_wen,
               ren_dst_arch, ren_dst_phys,
               com_valid, com_dst_wen, com_dst_arch, com_dst_phys, recover,
        input  ren_src1_phys, ren_src2_phys, ren_old_phys, ren_ready
    );

    modport slave (
        input  ren_valid, ren_src1_arch, ren_src2_arch, ren_dst_wen,
               ren_dst_arch, ren_dst_phys,
               com_valid, com_dst_wen, com_dst_arch, com_dst_phys, recover,
        output ren_src1_phys, ren_src2_phys, ren_old_phys, ren_ready
    );
endinterface
`default_nettype wire

// File: rtl/rat_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : rat_multiport
//  Description : Multi-ported register alias table. Holds a speculative
//                front-end map (spec_map) and a committed map (ret_map).
//                Renames RENAME_WIDTH instructions per cycle with intra-group
//                dependency bypass, commits RENAME_WIDTH retirements per
//                cycle, and restores spec_map from ret_map on recover.
//  Ports       : clk   - clock, all state updates on posedge
//                reset - asynchronous, active-low; both maps -> identity
//                bus   - rat_multiport_if.slave (rename / commit / recover)
//  Config      : RAT_R0_PIN_EN - when defined, arch reg 0 is pinned to
//                phys 0 (never renamed, never forwarded).
//  Revision    : 1.0 - initial release
// ============================================================================
module rat_multiport #(
    parameter int NUM_ARCH_REGS = 35,
    parameter int NUM_PHYS_REGS = 64,
    parameter int RENAME_WIDTH  = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rat_multiport_if.slave     bus
);
    localparam int LA = $clog2(NUM_ARCH_REGS);
    localparam int LP = $clog2(NUM_PHYS_REGS);
    localparam logic [LA:0] c_num_arch = (LA+1)'(NUM_ARCH_REGS);
`ifdef RAT_R0_PIN_EN
    localparam bit c_pin_r0 = 1'b1;
`else
    localparam bit c_pin_r0 = 1'b0;
`endif

    logic [LP-1:0] spec_map [NUM_ARCH_REGS];
    logic [LP-1:0] ret_map  [NUM_ARCH_REGS];

    logic [LP-1:0] w_spec_next [NUM_ARCH_REGS];
    logic [LP-1:0] w_ret_next  [NUM_ARCH_REGS];
    logic [RENAME_WIDTH-1:0]    w_fwd;
    logic [RENAME_WIDTH*LP-1:0] w_src1_phys;
    logic [RENAME_WIDTH*LP-1:0] w_src2_phys;
    logic [RENAME_WIDTH*LP-1:0] w_old_phys;

    // An arch index is "mapped" when it is in range and (if pinning is on)
    // is not reg 0. Unmapped indices read as phys 0, are never written and
    // never take part in intra-group forwarding.
    function automatic logic arch_mapped(input logic [LA-1:0] a);
        return ({1'b0, a} < c_num_arch) && !(c_pin_r0 && (a == '0));
    endfunction

    // Slot j produces a destination that younger slots must see.
    always_comb begin
        w_fwd = '0;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            w_fwd[j] = bus.ren_valid[j] && bus.ren_dst_wen[j] &&
                       arch_mapped(bus.ren_dst_arch[j*LA +: LA]);
        end
    end

    // Lookup: start from spec_map, then let each older writing slot override
    // in ascending order so the youngest older producer wins.
    always_comb begin
        w_src1_phys = '0;
        w_src2_phys = '0;
        w_old_phys  = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (arch_mapped(bus.ren_src1_arch[k*LA +: LA]))
                w_src1_phys[k*LP +: LP] = spec_map[bus.ren_src1_arch[k*LA +: LA]];
            if (arch_mapped(bus.ren_src2_arch[k*LA +: LA]))
                w_src2_phys[k*LP +: LP] = spec_map[bus.ren_src2_arch[k*LA +: LA]];
            if (arch_mapped(bus.ren_dst_arch[k*LA +: LA]))
                w_old_phys[k*LP +: LP]  = spec_map[bus.ren_dst_arch[k*LA +: LA]];
            for (int j = 0; j < k; j++) begin
                if (w_fwd[j]) begin
                    if (bus.ren_dst_arch[j*LA +: LA] == bus.ren_src1_arch[k*LA +: LA])
                        w_src1_phys[k*LP +: LP] = bus.ren_dst_phys[j*LP +: LP];
                    if (bus.ren_dst_arch[j*LA +: LA] == bus.ren_src2_arch[k*LA +: LA])
                        w_src2_phys[k*LP +: LP] = bus.ren_dst_phys[j*LP +: LP];
                    if (bus.ren_dst_arch[j*LA +: LA] == bus.ren_dst_arch[k*LA +: LA])
                        w_old_phys[k*LP +: LP]  = bus.ren_dst_phys[j*LP +: LP];
                end
            end
        end
    end

    // Next speculative map from this cycle's renames (highest slot wins).
    always_comb begin
        w_spec_next = spec_map;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (w_fwd[k])
                w_spec_next[bus.ren_dst_arch[k*LA +: LA]] = bus.ren_dst_phys[k*LP +: LP];
        end
    end

    // Next committed map (highest slot wins). Recover copies this value so
    // commits landing on the same edge are not lost.
    always_comb begin
        w_ret_next = ret_map;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (bus.com_valid[k] && bus.com_dst_wen[k] &&
                arch_mapped(bus.com_dst_arch[k*LA +: LA]))
                w_ret_next[bus.com_dst_arch[k*LA +: LA]] = bus.com_dst_phys[k*LP +: LP];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                spec_map[i] <= LP'(i);
                ret_map[i]  <= LP'(i);
            end
        end else begin
            ret_map <= w_ret_next;
            if (bus.recover)
                spec_map <= w_ret_next;
            else
                spec_map <= w_spec_next;
        end
    end

    assign bus.ren_src1_phys = w_src1_phys;
    assign bus.ren_src2_phys = w_src2_phys;
    assign bus.ren_old_phys  = w_old_phys;
    assign bus.ren_ready     = !bus.recover;

endmodule
`default_nettype wire

// File: tb/tb_rat_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rat_multiport
//  Description : Scoreboard bench for rat_multiport. The stimulus process
//                queues hand-computed expected outputs tagged with the cycle
//                they belong to; a monitor on the falling edge pops and
//                compares them against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_multiport;
    localparam int NUM_ARCH_REGS = 35;
    localparam int NUM_PHYS_REGS = 64;
    localparam int RENAME_WIDTH  = 2;
    localparam int LA = $clog2(NUM_ARCH_REGS);
    localparam int LP = $clog2(NUM_PHYS_REGS);
`ifdef RAT_R0_PIN_EN
    localparam logic [LP-1:0] c_r0_exp = 6'd0;
`else
    localparam logic [LP-1:0] c_r0_exp = 6'd45;
`endif

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    rat_multiport_if #(
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .RENAME_WIDTH  (RENAME_WIDTH)
    ) bus ();

    rat_multiport #(
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .RENAME_WIDTH  (RENAME_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0/1 src1 slot0/1, 2/3 src2 slot0/1, 4/5 old slot0/1, 6 ready
    typedef struct {
        int            cyc;
        int            sel;
        logic [LP-1:0] val;
        string         name;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [LP-1:0] act;

    function automatic logic [LP-1:0] pick(input int sel);
        int s;
        s = sel % 2;
        case (sel / 2)
            0:       return bus.ren_src1_phys[s*LP +: LP];
            1:       return bus.ren_src2_phys[s*LP +: LP];
            2:       return bus.ren_old_phys[s*LP +: LP];
            default: return {{(LP-1){1'b0}}, bus.ren_ready};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = pick(e.sel);
            n_vec++;
            if (e.cyc != cyc || act !== e.val) begin
                n_err++;
                $display("FAIL %s: cycle %0d got %0d expected %0d",
                         e.name, cyc, act, e.val);
            end
        end
    end

    task automatic expect_out(input int sel, input logic [LP-1:0] val, input string name);
        exp_t x;
        x.cyc  = cyc;
        x.sel  = sel;
        x.val  = val;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic clear();
        bus.ren_valid     = '0;
        bus.ren_src1_arch = '0;
        bus.ren_src2_arch = '0;
        bus.ren_dst_wen   = '0;
        bus.ren_dst_arch  = '0;
        bus.ren_dst_phys  = '0;
        bus.com_valid     = '0;
        bus.com_dst_wen   = '0;
        bus.com_dst_arch  = '0;
        bus.com_dst_phys  = '0;
        bus.recover       = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic set_ren(input int s, input logic [LA-1:0] s1, input logic [LA-1:0] s2,
                           input logic wen, input logic [LA-1:0] dst, input logic [LP-1:0] ph);
        bus.ren_valid[s]            = 1'b1;
        bus.ren_src1_arch[s*LA +: LA] = s1;
        bus.ren_src2_arch[s*LA +: LA] = s2;
        bus.ren_dst_wen[s]          = wen;
        bus.ren_dst_arch[s*LA +: LA]  = dst;
        bus.ren_dst_phys[s*LP +: LP]  = ph;
    endtask

    task automatic set_com(input int s, input logic [LA-1:0] a, input logic [LP-1:0] ph);
        bus.com_valid[s]            = 1'b1;
        bus.com_dst_wen[s]          = 1'b1;
        bus.com_dst_arch[s*LA +: LA]  = a;
        bus.com_dst_phys[s*LP +: LP]  = ph;
    endtask

    initial begin
        reset = 1'b0;
        clear();
        next();
        // Lookups while held in reset see the identity map
        set_ren(0, 6'd5, 6'd0, 1'b0, 6'd7, 6'd0);
        expect_out(0, 6'd5, "in_rst_src1");
        expect_out(4, 6'd7, "in_rst_old");

        next();
        reset = 1'b1;
        set_ren(0, 6'd5, 6'd0, 1'b0, 6'd7, 6'd0);
        expect_out(0, 6'd5, "post_rst_src1");
        expect_out(4, 6'd7, "post_rst_old");
        expect_out(6, 6'd1, "ready_idle");

        // Intra-group bypass
        next();
        set_ren(0, 6'd3, 6'd0, 1'b1, 6'd3, 6'd40);
        set_ren(1, 6'd3, 6'd7, 1'b1, 6'd3, 6'd41);
        expect_out(0, 6'd3,  "slot0_src1");
        expect_out(1, 6'd40, "byp_src1");
        expect_out(3, 6'd7,  "byp_src2_nomatch");
        expect_out(4, 6'd3,  "slot0_old");
        expect_out(5, 6'd40, "byp_old");

        next();
        set_ren(0, 6'd3, 6'd0, 1'b0, 6'd0, 6'd0);
        expect_out(0, 6'd41, "upd_highest_slot");

        // Rename / commit / recover with simultaneous commit
        next();
        set_ren(0, 6'd0, 6'd0, 1'b1, 6'd8, 6'd50);
        next();
        set_com(0, 6'd8, 6'd50);
        set_ren(0, 6'd0, 6'd0, 1'b1, 6'd8, 6'd51);
        expect_out(4, 6'd50, "old8");
        next();
        bus.recover = 1'b1;
        set_com(0, 6'd9, 6'd52);
        set_ren(0, 6'd0, 6'd0, 1'b1, 6'd10, 6'd55);
        expect_out(6, 6'd0, "ready_recover");
        next();
        set_ren(0, 6'd8, 6'd9, 1'b0, 6'd0, 6'd0);
        set_ren(1, 6'd10, 6'd3, 1'b0, 6'd0, 6'd0);
        expect_out(0, 6'd50, "rec_8");
        expect_out(2, 6'd52, "rec_9_same_edge");
        expect_out(1, 6'd10, "rec_discard_10");
        expect_out(3, 6'd3,  "rec_3_uncommitted");
        expect_out(6, 6'd1,  "ready_after_rec");

        // Double commit to LO, then recover
        next();
        set_com(0, 6'd33, 6'd60);
        set_com(1, 6'd33, 6'd61);
        next();
        bus.recover = 1'b1;
        next();
        set_ren(0, 6'd33, 6'd40, 1'b1, 6'd40, 6'd30);
        set_ren(1, 6'd34, 6'd63, 1'b0, 6'd0, 6'd0);
        expect_out(0, 6'd61, "lo_high_slot");
        expect_out(2, 6'd0,  "oor_src");
        expect_out(4, 6'd0,  "oor_old");
        expect_out(1, 6'd34, "hi_identity");
        expect_out(3, 6'd0,  "oor_src_63");
        next();
        set_ren(0, 6'd40, 6'd0, 1'b0, 6'd0, 6'd0);
        expect_out(0, 6'd0, "oor_write_ignored");

        // Reset asserted mid-stream
        next();
        set_ren(0, 6'd0, 6'd0, 1'b1, 6'd12, 6'd20);
        set_ren(1, 6'd0, 6'd0, 1'b1, 6'd13, 6'd21);
        next();
        set_ren(0, 6'd12, 6'd13, 1'b0, 6'd0, 6'd0);
        expect_out(0, 6'd20, "pre_rst_12");
        expect_out(2, 6'd21, "pre_rst_13");
        next();
        set_ren(0, 6'd12, 6'd0, 1'b0, 6'd0, 6'd0);
        set_ren(1, 6'd13, 6'd0, 1'b0, 6'd0, 6'd0);
        #1 reset = 1'b0;
        expect_out(0, 6'd12, "mid_rst_12");
        expect_out(1, 6'd13, "mid_rst_13");
        next();
        reset = 1'b1;
        set_ren(0, 6'd12, 6'd0, 1'b0, 6'd0, 6'd0);
        expect_out(0, 6'd12, "after_rst_12");

        // Arch reg 0 behaviour depends on pinning
        next();
        set_ren(0, 6'd0, 6'd0, 1'b1, 6'd0, 6'd45);
        set_ren(1, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
        expect_out(4, 6'd0,     "r0_old");
        expect_out(1, c_r0_exp, "r0_bypass");
        next();
        set_ren(0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
        expect_out(0, c_r0_exp, "r0_next");

        next();
        next();
        if (sb.size() > 0) begin
            n_err += sb.size();
            $display("FAIL scoreboard_drain: %0d entries left, 0 required", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
